fetch_queue: RTL

Parametrised instruction fetch queue placed between the IF stage and the IF/ID pipeline register. It decouples instruction-cache stalls from decode back-pressure, tags each instruction with its PC and halt-detect bit, and is flushed on a taken branch or jump resolved in MEM. It replaces the single-entry hold-mux at IF/ID with a DEPTH-entry FIFO. Once a halt has been enqueued, it stops accepting fetches.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fq_ptr.sv | 24 ++
 rtl/fetch_queue.sv | 126 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths and the fetch queue entry layout.
package cpu_pkg;

  localparam int CPU_DATA_W = 16;
  localparam int CPU_ADDR_W = 16;

  // One fetch queue slot at the default widths: instruction, its PC, halt-detect bit.
  typedef struct packed {
    logic [CPU_DATA_W-1:0] instr;
    logic [CPU_ADDR_W-1:0] pc;
    logic                  hlt;
  } fq_entry_t;

endpackage

// File: rtl/fq_ptr.sv
// Wrap-around pointer register with synchronous clear and increment enable.
module fq_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  // Clear wins over increment; the pointer wraps naturally at 2**W.
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between IF and IF/ID: DEPTH-entry FIFO of {instr, pc, hlt},
// flushed on a MEM redirect and closed to new fetches once a halt has been accepted.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DATA_W = CPU_DATA_W,
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic              in_hlt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_hlt,
  input  logic              flush,
  output logic [CNT_W-1:0]  count,
  output logic              hlt_lock
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] pc;
    logic              hlt;
  } entry_t;

  typedef enum logic {
    LOCK_OPEN   = 1'b0,
    LOCK_LOCKED = 1'b1
  } lock_state_t;

  entry_t             r_mem [DEPTH];
  logic [CNT_W-1:0]   r_count;
  lock_state_t        r_lockState;

  logic [PTR_W-1:0]   w_rdPtr;
  logic [PTR_W-1:0]   w_wrPtr;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic               w_clear;
  entry_t             w_head;

  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign hlt_lock = (r_lockState == LOCK_LOCKED);

  // in_ready looks only at local state, so there is no combinational in->out path.
  assign in_ready  = ~w_full & ~hlt_lock;
  assign out_valid = ~w_empty;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_clear   = rst | flush;

  fq_ptr #(.W(PTR_W)) u_rdPtr (
    .clk     (clk),
    .i_clear (w_clear),
    .i_inc   (w_pop),
    .o_ptr   (w_rdPtr)
  );

  fq_ptr #(.W(PTR_W)) u_wrPtr (
    .clk     (clk),
    .i_clear (w_clear),
    .i_inc   (w_push),
    .o_ptr   (w_wrPtr)
  );

  // Storage is never reset; a push coinciding with reset or flush is dropped.
  always_ff @(posedge clk) begin
    if (w_push && !w_clear) begin
      r_mem[w_wrPtr] <= '{instr: in_instr, pc: in_pc, hlt: in_hlt};
    end
  end

  // Occupancy: reset/flush empty the queue, otherwise track push and pop.
  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Halt lock: closes on an accepted halt push, reopens only on reset or flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lockState <= LOCK_OPEN;
    end else begin
      case (r_lockState)
        LOCK_OPEN: begin
          if (!flush && w_push && in_hlt) begin
            r_lockState <= LOCK_LOCKED;
          end
        end
        LOCK_LOCKED: begin
          if (flush) begin
            r_lockState <= LOCK_OPEN;
          end
        end
        default: r_lockState <= LOCK_OPEN;
      endcase
    end
  end

  assign w_head    = r_mem[w_rdPtr];
  assign out_instr = out_valid ? w_head.instr : '0;
  assign out_pc    = out_valid ? w_head.pc    : '0;
  assign out_hlt   = out_valid ? w_head.hlt   : 1'b0;
  assign count     = r_count;

endmodule
